// File: rtl/regfile_dbg_pkg.sv
// rtl/regfile_dbg_pkg.sv - shared state, defaults and request type for the register file debug arbiter
package regfile_dbg_pkg;

  localparam int DEF_BUSWIDTH   = 32;
  localparam int DEF_REGNUMLOG2 = 5;

  typedef enum logic [1:0] {
    IDLE,
    HALT,
    ACCESS,
    RESP
  } dbg_state_e;

  typedef struct packed {
    logic                      we;
    logic [DEF_REGNUMLOG2-1:0] addr;
    logic [DEF_BUSWIDTH-1:0]   wdata;
  } dbg_req_t;

endpackage

// File: rtl/regfile_dbg_arbiter_if.sv
// rtl/regfile_dbg_arbiter_if.sv - debug request/response bus between debug module and arbiter
// Optional REGFILE_DBG_AUTOINC_EN adds the dbg_req_burst field.
interface regfile_dbg_arbiter_if
  import regfile_dbg_pkg::*;
#(
  parameter int BUSWIDTH   = DEF_BUSWIDTH,
  parameter int REGNUMLOG2 = DEF_REGNUMLOG2
);
  logic                  dbg_req_valid;
  logic                  dbg_req_ready;
  logic                  dbg_req_we;
  logic [REGNUMLOG2-1:0] dbg_req_addr;
  logic [BUSWIDTH-1:0]   dbg_req_wdata;
  logic                  dbg_resp_valid;
  logic                  dbg_resp_ready;
  logic [BUSWIDTH-1:0]   dbg_resp_rdata;
  logic                  dbg_resp_err;
`ifdef REGFILE_DBG_AUTOINC_EN
  logic [7:0]            dbg_req_burst;

  modport master (
    output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_req_burst, dbg_resp_ready,
    input  dbg_req_ready, dbg_resp_valid, dbg_resp_rdata, dbg_resp_err
  );
  modport slave (
    input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_req_burst, dbg_resp_ready,
    output dbg_req_ready, dbg_resp_valid, dbg_resp_rdata, dbg_resp_err
  );
`else
  modport master (
    output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_resp_ready,
    input  dbg_req_ready, dbg_resp_valid, dbg_resp_rdata, dbg_resp_err
  );
  modport slave (
    input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_resp_ready,
    output dbg_req_ready, dbg_resp_valid, dbg_resp_rdata, dbg_resp_err
  );
`endif
endinterface

// File: rtl/regfile_wport_mux.sv
// rtl/regfile_wport_mux.sv - register file write port mux; core writeback always beats debug
module regfile_wport_mux
  import regfile_dbg_pkg::*;
#(
  parameter int BUSWIDTH   = DEF_BUSWIDTH,
  parameter int REGNUMLOG2 = DEF_REGNUMLOG2
) (
  input  logic                  core_wen,
  input  logic [REGNUMLOG2-1:0] core_waddr,
  input  logic [BUSWIDTH-1:0]   core_wdata,
  input  logic                  dbg_wen,
  input  logic [REGNUMLOG2-1:0] dbg_waddr,
  input  logic [BUSWIDTH-1:0]   dbg_wdata,
  output logic                  rf_wen,
  output logic [REGNUMLOG2-1:0] rf_waddr,
  output logic [BUSWIDTH-1:0]   rf_wdata
);
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (core_wen) begin
      rf_wen   = 1'b1;
      rf_waddr = core_waddr;
      rf_wdata = core_wdata;
    end else if (dbg_wen) begin
      rf_wen   = 1'b1;
      rf_waddr = dbg_waddr;
      rf_wdata = dbg_wdata;
    end
  end
endmodule

// File: rtl/regfile_dbg_arbiter.sv
// rtl/regfile_dbg_arbiter.sv - halts the pipeline and sequences one debug register access
// Optional REGFILE_DBG_AUTOINC_EN: each request runs dbg_req_burst extra auto-incrementing accesses.
module regfile_dbg_arbiter
  import regfile_dbg_pkg::*;
#(
  parameter int BUSWIDTH     = DEF_BUSWIDTH,
  parameter int REGNUMLOG2   = DEF_REGNUMLOG2,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_dbg_arbiter_if.slave  dbg,
  output logic                  halt_req,
  input  logic                  halt_ack,
  input  logic                  core_wen,
  input  logic [REGNUMLOG2-1:0] core_waddr,
  input  logic [BUSWIDTH-1:0]   core_wdata,
  output logic                  rf_wen,
  output logic [REGNUMLOG2-1:0] rf_waddr,
  output logic [BUSWIDTH-1:0]   rf_wdata,
  output logic [REGNUMLOG2-1:0] rf_raddr,
  output logic                  rf_rsel,
  input  logic [BUSWIDTH-1:0]   rf_rdata
);
  localparam int CW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALT_TIMEOUT - 1);

  dbg_state_e            state, state_nxt;
  logic                  req_we;
  logic [REGNUMLOG2-1:0] req_addr;
  logic [BUSWIDTH-1:0]   req_wdata;
  logic [CW-1:0]         cnt;
  logic                  err;
  logic [BUSWIDTH-1:0]   rdata;
  logic                  access_done;
  logic                  dbg_wen;
  logic                  more;

`ifdef REGFILE_DBG_AUTOINC_EN
  logic [7:0] burst_left;
  assign more = (burst_left != 8'd0) && !err;
`else
  assign more = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    dbg.dbg_req_ready  = 1'b0;
    dbg.dbg_resp_valid = 1'b0;
    halt_req           = 1'b0;
    rf_rsel            = 1'b0;
    access_done        = 1'b0;
    dbg_wen            = 1'b0;
    case (state)
      IDLE: begin
        dbg.dbg_req_ready = 1'b1;
        if (dbg.dbg_req_valid) state_nxt = HALT;
      end
      HALT: begin
        halt_req = 1'b1;
        if (halt_ack)             state_nxt = ACCESS;
        else if (cnt == CNT_LAST) state_nxt = RESP;
      end
      ACCESS: begin
        halt_req = 1'b1;
        rf_rsel  = !req_we;
        // A core writeback in this cycle owns the write port; retry next cycle.
        if (!core_wen) begin
          access_done = 1'b1;
          dbg_wen     = req_we && (req_addr != '0);
          state_nxt   = RESP;
        end
      end
      RESP: begin
        dbg.dbg_resp_valid = 1'b1;
        halt_req           = !err;
        if (dbg.dbg_resp_ready) state_nxt = more ? ACCESS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      rdata      <= '0;
`ifdef REGFILE_DBG_AUTOINC_EN
      burst_left <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: if (dbg.dbg_req_valid) begin
          req_we     <= dbg.dbg_req_we;
          req_addr   <= dbg.dbg_req_addr;
          req_wdata  <= dbg.dbg_req_wdata;
          cnt        <= '0;
`ifdef REGFILE_DBG_AUTOINC_EN
          burst_left <= dbg.dbg_req_burst;
`endif
        end
        HALT: begin
          cnt <= cnt + 1'b1;
          if (!halt_ack && cnt == CNT_LAST) err <= 1'b1;
        end
        ACCESS: if (access_done) begin
          rdata <= (!req_we && req_addr != '0) ? rf_rdata : '0;
        end
        RESP: if (dbg.dbg_resp_ready) begin
          err   <= 1'b0;
          rdata <= '0;
`ifdef REGFILE_DBG_AUTOINC_EN
          if (more) begin
            burst_left <= burst_left - 8'd1;
            req_addr   <= (req_addr == '1) ? REGNUMLOG2'(1) : req_addr + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign dbg.dbg_resp_rdata = rdata;
  assign dbg.dbg_resp_err   = err;
  assign rf_raddr           = rf_rsel ? req_addr : '0;

  regfile_wport_mux #(
    .BUSWIDTH   (BUSWIDTH),
    .REGNUMLOG2 (REGNUMLOG2)
  ) u_wport_mux (
    .core_wen   (core_wen),
    .core_waddr (core_waddr),
    .core_wdata (core_wdata),
    .dbg_wen    (dbg_wen),
    .dbg_waddr  (req_addr),
    .dbg_wdata  (req_wdata),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );
endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// tb/tb_regfile_dbg_arbiter.sv - directed and randomized bench for regfile_dbg_arbiter
module tb_regfile_dbg_arbiter;
  import regfile_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_req, halt_ack;
  logic        core_wen, rf_wen, rf_rsel;
  logic [4:0]  core_waddr, rf_waddr, rf_raddr;
  logic [31:0] core_wdata, rf_wdata, rf_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_dbg_arbiter_if #(.BUSWIDTH(32), .REGNUMLOG2(5)) dbg ();

  regfile_dbg_arbiter #(.BUSWIDTH(32), .REGNUMLOG2(5), .HALT_TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .dbg        (dbg),
    .halt_req   (halt_req),
    .halt_ack   (halt_ack),
    .core_wen   (core_wen),
    .core_waddr (core_waddr),
    .core_wdata (core_wdata),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_raddr   (rf_raddr),
    .rf_rsel    (rf_rsel),
    .rf_rdata   (rf_rdata)
  );

  // Register file stand-in; x0 returns garbage so the arbiter must force zero itself.
  logic [31:0] regs [32];
  int          wen_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_wen) begin
      regs[rf_waddr] <= rf_wdata;
      wen_cnt        <= wen_cnt + 1;
    end
  end
  assign rf_rdata = (rf_raddr == 5'd0) ? 32'hCAFE_F00D : regs[rf_raddr];

  logic [31:0] model [32];

  task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg.dbg_req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    dbg.dbg_req_valid = 1'b1;
    dbg.dbg_req_we    = we;
    dbg.dbg_req_addr  = a;
    dbg.dbg_req_wdata = d;
    @(negedge clk);
    dbg.dbg_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (dbg.dbg_resp_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic ack_resp();
    dbg.dbg_resp_ready = 1'b1;
    @(negedge clk);
    dbg.dbg_resp_ready = 1'b0;
    halt_ack           = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    halt_ack = 1'b0; core_wen = 1'b0; core_waddr = '0; core_wdata = '0;
    dbg.dbg_req_valid = 1'b0; dbg.dbg_req_we = 1'b0; dbg.dbg_req_addr = '0;
    dbg.dbg_req_wdata = '0; dbg.dbg_resp_ready = 1'b0;
`ifdef REGFILE_DBG_AUTOINC_EN
    dbg.dbg_req_burst = 8'd0;
`endif
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({halt_req, dbg.dbg_resp_valid, dbg.dbg_resp_err, rf_wen, rf_rsel} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {halt_req, dbg.dbg_resp_valid, dbg.dbg_resp_err, rf_wen, rf_rsel});
    end
    n_checks++;
    if (dbg.dbg_req_ready !== 1'b1 || dbg.dbg_resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b rdata=%h expected ready=1 rdata=0",
               dbg.dbg_req_ready, dbg.dbg_resp_rdata);
    end
  endtask

  task automatic test_write();
    bit ok; int n; int w0;
    w0 = wen_cnt;
    issue(1'b1, 5'd5, 32'hDEAD_BEEF, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL write_accept: got %b expected 1", ok); end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({halt_req, dbg.dbg_req_ready, dbg.dbg_resp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL write_halting: got %b expected 100", {halt_req, dbg.dbg_req_ready, dbg.dbg_resp_valid});
    end
    halt_ack = 1'b1;
    wait_resp(10, n);
    n_checks++;
    if (n !== 2) begin n_fail++; $display("FAIL write_latency: got %0d expected 2", n); end
    n_checks++;
    if ({dbg.dbg_resp_err, halt_req, dbg.dbg_resp_rdata} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL write_resp: err=%b halt=%b rdata=%h expected err=0 halt=1 rdata=0",
               dbg.dbg_resp_err, halt_req, dbg.dbg_resp_rdata);
    end
    ack_resp();
    n_checks++;
    if ({halt_req, dbg.dbg_resp_valid, dbg.dbg_req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL write_release: got %b expected 001", {halt_req, dbg.dbg_resp_valid, dbg.dbg_req_ready});
    end
    model[5] = 32'hDEAD_BEEF;
    n_checks++;
    if (wen_cnt - w0 !== 1 || regs[5] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_effect: pulses=%0d x5=%h expected 1 deadbeef", wen_cnt - w0, regs[5]);
    end
  endtask

  task automatic test_read_hold();
    bit ok; int n;
    @(negedge clk);
    core_wen = 1'b1; core_waddr = 5'd7; core_wdata = 32'h1234_5678;
    @(negedge clk);
    core_wen = 1'b0;
    model[7] = 32'h1234_5678;
    issue(1'b0, 5'd7, 32'h0, ok);
    halt_ack = 1'b1;
    wait_resp(10, n);
    n_checks++;
    if (n !== 2 || dbg.dbg_resp_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL read_data: lat=%0d rdata=%h expected 2 12345678", n, dbg.dbg_resp_rdata);
    end
    // Overwrite x7 while the response waits; the held response must not follow it.
    core_wen = 1'b1; core_waddr = 5'd7; core_wdata = 32'h0BAD_F00D;
    model[7] = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      core_wen = 1'b0;
      n_checks++;
      if ({dbg.dbg_resp_valid, dbg.dbg_resp_rdata} !== {1'b1, 32'h1234_5678}) begin
        n_fail++;
        $display("FAIL read_hold[%0d]: valid=%b rdata=%h expected 1 12345678",
                 i, dbg.dbg_resp_valid, dbg.dbg_resp_rdata);
      end
    end
    ack_resp();
  endtask

  task automatic test_x0();
    bit ok; int n; int w0;
    w0 = wen_cnt;
    issue(1'b1, 5'd0, 32'hFFFF_FFFF, ok);
    halt_ack = 1'b1;
    wait_resp(10, n);
    n_checks++;
    if (n !== 2 || dbg.dbg_resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write_resp: lat=%0d err=%b expected 2 0", n, dbg.dbg_resp_err);
    end
    ack_resp();
    n_checks++;
    if (wen_cnt !== w0) begin n_fail++; $display("FAIL x0_no_wen: got %0d pulses expected 0", wen_cnt - w0); end
    issue(1'b0, 5'd0, 32'h0, ok);
    halt_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rf_rsel, rf_raddr} !== {1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL x0_read_port: rsel=%b raddr=%0d expected 1 0", rf_rsel, rf_raddr);
    end
    wait_resp(10, n);
    n_checks++;
    if (n !== 1 || dbg.dbg_resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_read: lat=%0d rdata=%h expected 1 0", n, dbg.dbg_resp_rdata);
    end
    ack_resp();
  endtask

  task automatic test_core_contention();
    bit ok; int n; int w0;
    w0 = wen_cnt;
    issue(1'b1, 5'd3, 32'hA, ok);
    halt_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      core_wen = 1'b1; core_waddr = 5'd9; core_wdata = 32'hB;
      #1;
      n_checks++;
      if ({rf_wen, rf_waddr, rf_wdata, dbg.dbg_resp_valid} !== {1'b1, 5'd9, 32'hB, 1'b0}) begin
        n_fail++;
        $display("FAIL contention_core[%0d]: wen=%b addr=%0d data=%h valid=%b expected 1 9 b 0",
                 i, rf_wen, rf_waddr, rf_wdata, dbg.dbg_resp_valid);
      end
    end
    @(negedge clk);
    core_wen = 1'b0;
    #1;
    n_checks++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hA}) begin
      n_fail++;
      $display("FAIL contention_dbg: wen=%b addr=%0d data=%h expected 1 3 a", rf_wen, rf_waddr, rf_wdata);
    end
    wait_resp(5, n);
    n_checks++;
    if (n !== 1) begin n_fail++; $display("FAIL contention_resp: lat=%0d expected 1", n); end
    ack_resp();
    model[9] = 32'hB;
    model[3] = 32'hA;
    n_checks++;
    if (wen_cnt - w0 !== 3 || regs[9] !== 32'hB || regs[3] !== 32'hA) begin
      n_fail++;
      $display("FAIL contention_effect: pulses=%0d x9=%h x3=%h expected 3 b a", wen_cnt - w0, regs[9], regs[3]);
    end
  endtask

  task automatic test_timeout();
    bit ok; int halt_cycles; int w0;
    w0 = wen_cnt;
    halt_cycles = 0;
    issue(1'b1, 5'd4, 32'h5555_AAAA, ok);
    for (int i = 0; i < 400; i++) begin
      if (dbg.dbg_resp_valid === 1'b1) break;
      if (halt_req === 1'b1) halt_cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (dbg.dbg_resp_valid !== 1'b1 || halt_cycles !== 255) begin
      n_fail++;
      $display("FAIL timeout_cycles: valid=%b halt_cycles=%0d expected 1 255", dbg.dbg_resp_valid, halt_cycles);
    end
    n_checks++;
    if ({dbg.dbg_resp_err, halt_req, dbg.dbg_resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_resp: err=%b halt=%b rdata=%h expected 1 0 0",
               dbg.dbg_resp_err, halt_req, dbg.dbg_resp_rdata);
    end
    ack_resp();
    n_checks++;
    if (wen_cnt !== w0 || regs[4] !== model[4]) begin
      n_fail++;
      $display("FAIL timeout_no_write: pulses=%0d x4=%h expected 0 %h", wen_cnt - w0, regs[4], model[4]);
    end
  endtask

  task automatic test_reset_in_resp();
    bit ok; int n;
    issue(1'b0, 5'd5, 32'h0, ok);
    halt_ack = 1'b1;
    wait_resp(10, n);
    n_checks++;
    if (n !== 2) begin n_fail++; $display("FAIL rst_resp_reach: lat=%0d expected 2", n); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({halt_req, dbg.dbg_resp_valid, dbg.dbg_resp_err, rf_wen, rf_rsel, rf_raddr, dbg.dbg_resp_rdata,
         dbg.dbg_req_ready} !== {10'b0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_in_resp: halt=%b valid=%b err=%b wen=%b rsel=%b rdata=%h ready=%b expected zeros ready=1",
               halt_req, dbg.dbg_resp_valid, dbg.dbg_resp_err, rf_wen, rf_rsel, dbg.dbg_resp_rdata,
               dbg.dbg_req_ready);
    end
    rst      = 1'b0;
    halt_ack = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic test_random();
    bit ok; int n; int w0; int exp_w; int ack_dly;
    logic we; logic [4:0] a; logic [31:0] d; logic [31:0] exp_rd;
    for (int t = 0; t < 40; t++) begin
      we      = 1'($urandom_range(0, 1));
      a       = 5'($urandom_range(0, 31));
      d       = $urandom;
      ack_dly = $urandom_range(0, 4);
      w0      = wen_cnt;
      exp_w   = 0;
      issue(we, a, d, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_accept[%0d]: got %b expected 1", t, ok); end
      for (int k = 0; k < ack_dly; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          core_wen   = 1'b1;
          core_waddr = 5'($urandom_range(1, 31));
          core_wdata = $urandom;
          model[core_waddr] = core_wdata;
          exp_w++;
        end
        @(negedge clk);
        core_wen = 1'b0;
      end
      halt_ack = 1'b1;
      wait_resp(10, n);
      exp_rd = (we || a == 5'd0) ? 32'h0 : model[a];
      if (we && a != 5'd0) begin
        model[a] = d;
        exp_w++;
      end
      n_checks++;
      if ({n, dbg.dbg_resp_err, dbg.dbg_resp_rdata} !== {32'sd2, 1'b0, exp_rd}) begin
        n_fail++;
        $display("FAIL rand_resp[%0d]: lat=%0d err=%b rdata=%h expected 2 0 %h",
                 t, n, dbg.dbg_resp_err, dbg.dbg_resp_rdata, exp_rd);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ack_resp();
      n_checks++;
      if (wen_cnt - w0 !== exp_w) begin
        n_fail++;
        $display("FAIL rand_wen[%0d]: got %0d pulses expected %0d", t, wen_cnt - w0, exp_w);
      end
    end
    for (int i = 1; i < 32; i++) begin
      n_checks++;
      if (regs[i] !== model[i]) begin
        n_fail++;
        $display("FAIL rand_regs[x%0d]: got %h expected %h", i, regs[i], model[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_x0();
    test_core_contention();
    test_timeout();
    test_reset_in_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
